// File: rtl/dmem_pkg.sv
// Shared types and helpers for the synchronous data memory.
package dmem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } dmem_state_t;

    // Widest word merge_bytes handles; callers zero-extend and take the low bits.
    localparam int unsigned MaxDataWidth = 256;
    localparam int unsigned MaxStrbWidth = MaxDataWidth / 8;

    function automatic logic [MaxDataWidth-1:0] merge_bytes(
        input logic [MaxDataWidth-1:0] old_word,
        input logic [MaxDataWidth-1:0] new_word,
        input logic [MaxStrbWidth-1:0] strobe
    );
        logic [MaxDataWidth-1:0] merged;
        merged = old_word;
        for (int i = 0; i < int'(MaxStrbWidth); i++) begin
            if (strobe[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_ram_array.sv
// Byte-enabled storage array: one synchronous write port, one registered read port.
module dmem_ram_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned IDX_WIDTH  = 8
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [IDX_WIDTH-1:0]    waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    re_i,
    input  logic [IDX_WIDTH-1:0]    raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int unsigned StrbWidth = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[raddr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        rdata_q <= rdata_d;
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < int'(StrbWidth); i++) begin
                if (wstrb_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_sync.sv
// Load/store data memory: clear sweep after reset, valid/ready requests,
// one-cycle registered responses with out-of-range error reporting.
module data_memory_sync
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_address,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strobe,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_error,
    output logic                    clear_busy
);

    localparam int unsigned StrbWidth = DATA_WIDTH / 8;
    localparam int unsigned CntWidth  = $clog2(DEPTH + 1);
    localparam int unsigned IdxWidth  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dmem_state_t           state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_error_q, resp_error_d;
    logic                  resp_write_q, resp_write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [StrbWidth-1:0]  strobe_q, strobe_d;

    logic                  accept, in_range;
    logic                  ram_we, ram_re;
    logic [IdxWidth-1:0]   ram_idx;
    logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;
    logic [StrbWidth-1:0]  ram_strobe;
    logic [MaxDataWidth-1:0] merged_wide;
    logic                  unused_merge;

    assign req_ready  = (state_q == READY);
    assign clear_busy = (state_q == CLEAR);
    assign accept     = req_valid && req_ready;
    assign in_range   = (32'(req_address) < DEPTH);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_error_d = 1'b0;
        resp_write_d = 1'b0;
        wdata_d      = wdata_q;
        strobe_d     = strobe_q;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        ram_idx      = cnt_q[IdxWidth-1:0];
        ram_wdata    = '0;
        ram_strobe   = '1;

        unique case (state_q)
            CLEAR: begin
                ram_we = 1'b1;
                if (cnt_q == CntWidth'(DEPTH - 1)) begin
                    state_d = READY;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            READY: begin
                if (accept) begin
                    resp_valid_d = 1'b1;
                    resp_error_d = !in_range;
                    resp_write_d = req_write;
                    wdata_d      = req_wdata;
                    strobe_d     = req_strobe;
                    ram_idx      = req_address[IdxWidth-1:0];
                    ram_re       = in_range;
                    ram_we       = req_write && in_range;
                    ram_wdata    = req_wdata;
                    ram_strobe   = req_strobe;
                end
            end
        endcase

        // Nothing reaches the array on an edge where reset is sampled.
        if (reset) begin
            ram_we = 1'b0;
            ram_re = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CLEAR;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_write_q <= 1'b0;
            wdata_q      <= '0;
            strobe_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_write_q <= resp_write_d;
            wdata_q      <= wdata_d;
            strobe_q     <= strobe_d;
        end
    end

    dmem_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_WIDTH  (IdxWidth)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (ram_idx),
        .wdata_i (ram_wdata),
        .wstrb_i (ram_strobe),
        .re_i    (ram_re),
        .raddr_i (ram_idx),
        .rdata_o (ram_rdata)
    );

    // The array reads before it writes, so a store's post-write word is rebuilt here.
    always_comb begin
        merged_wide = merge_bytes(MaxDataWidth'(ram_rdata), MaxDataWidth'(wdata_q),
                                  MaxStrbWidth'(strobe_q));
        resp_rdata  = '0;
        if (resp_valid_q && !resp_error_q) begin
            resp_rdata = resp_write_q ? merged_wide[DATA_WIDTH-1:0] : ram_rdata;
        end
    end

    assign unused_merge = ^merged_wide[MaxDataWidth-1:DATA_WIDTH];
    assign resp_valid   = resp_valid_q;
    assign resp_error   = resp_valid_q && resp_error_q;

endmodule

// File: tb/tb_data_memory_sync.sv
// Self-checking bench for data_memory_sync (32-bit words, 4-bit address, 12 words).
module tb_data_memory_sync;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_address;
    logic [DW-1:0] req_wdata;
    logic [3:0]    req_strobe;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_error;
    logic          clear_busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [DEPTH];

    data_memory_sync #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_address (req_address),
        .req_wdata   (req_wdata),
        .req_strobe  (req_strobe),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_error  (resp_error),
        .clear_busy  (clear_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one edge.
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        req_valid   = 1'b1;
        req_write   = wr;
        req_address = a;
        req_wdata   = d;
        req_strobe  = s;
        tick();
        req_valid   = 1'b0;
    endtask

    // Reference model: returns the expected response and updates the memory image.
    function automatic void model_access(input logic wr, input logic [AW-1:0] a,
                                         input logic [31:0] d, input logic [3:0] s,
                                         output logic [31:0] exp_d, output logic exp_e);
        logic [31:0] mask;
        if (int'(a) >= DEPTH) begin
            exp_d = 32'h0;
            exp_e = 1'b1;
            return;
        end
        exp_e = 1'b0;
        if (wr) begin
            mask = 32'h0;
            for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
            model_mem[a] = (model_mem[a] & ~mask) | (d & mask);
        end
        exp_d = model_mem[a];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    endfunction

    // Counts cycles until req_ready rises (bounded); notes any response seen meanwhile.
    task automatic wait_ready(output int n, output logic saw_resp);
        n = 0;
        saw_resp = 1'b0;
        while (!req_ready && n < 40) begin
            tick();
            n++;
            if (resp_valid) saw_resp = 1'b1;
        end
    endtask

    task automatic test_reset();
        int n;
        logic saw;
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (req_ready !== 1'b0 || clear_busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctrl ready=%0b busy=%0b exp ready=0 busy=1", req_ready, clear_busy);
        end
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_error !== 1'b0) begin
            failures++;
            $display("FAIL reset_resp valid=%0b rdata=%h err=%0b exp 0/0/0",
                     resp_valid, resp_rdata, resp_error);
        end
        reset = 1'b0;
        wait_ready(n, saw);
        checks++;
        if (n !== DEPTH) begin
            failures++;
            $display("FAIL reset_ready_latency got=%0d exp=%0d", n, DEPTH);
        end
        checks++;
        if (clear_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy_fall got=%0b exp=0", clear_busy);
        end
        model_clear();
        for (int a = 0; a < DEPTH; a++) begin
            issue(1'b0, AW'(a), 32'h0, 4'h0);
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_error !== 1'b0) begin
                failures++;
                $display("FAIL reset_zero addr=%0d valid=%0b rdata=%h err=%0b exp 1/00000000/0",
                         a, resp_valid, resp_rdata, resp_error);
            end
        end
    endtask

    task automatic test_byte_strobe();
        logic [31:0] exp_d;
        logic        exp_e;
        logic [31:0] want [3];
        want[0] = 32'hDEADBEEF;
        want[1] = 32'hDEADBEAA;
        want[2] = 32'hDEADBEAA;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin
                    model_access(1'b1, 4'd5, 32'hDEADBEEF, 4'b1111, exp_d, exp_e);
                    issue(1'b1, 4'd5, 32'hDEADBEEF, 4'b1111);
                end
                1: begin
                    model_access(1'b1, 4'd5, 32'h000000AA, 4'b0001, exp_d, exp_e);
                    issue(1'b1, 4'd5, 32'h000000AA, 4'b0001);
                end
                default: begin
                    model_access(1'b0, 4'd5, 32'h0, 4'h0, exp_d, exp_e);
                    issue(1'b0, 4'd5, 32'h0, 4'h0);
                end
            endcase
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== want[k] || resp_error !== 1'b0) begin
                failures++;
                $display("FAIL strobe_step%0d valid=%0b rdata=%h err=%0b exp 1/%h/0",
                         k, resp_valid, resp_rdata, resp_error, want[k]);
            end
            tick();
            checks++;
            if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin
                failures++;
                $display("FAIL strobe_idle%0d valid=%0b rdata=%h exp 0/00000000",
                         k, resp_valid, resp_rdata);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d;
        logic        exp_e;
        model_access(1'b1, 4'd3, 32'h12345678, 4'hF, exp_d, exp_e);
        issue(1'b1, 4'd3, 32'h12345678, 4'hF);
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h12345678) begin
            failures++;
            $display("FAIL b2b_store valid=%0b rdata=%h exp 1/12345678", resp_valid, resp_rdata);
        end
        model_access(1'b0, 4'd3, 32'h0, 4'h0, exp_d, exp_e);
        issue(1'b0, 4'd3, 32'h0, 4'h0);
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h12345678) begin
            failures++;
            $display("FAIL b2b_load valid=%0b rdata=%h exp 1/12345678", resp_valid, resp_rdata);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] exp_d;
        logic        exp_e;
        model_access(1'b1, 4'd11, 32'hCAFEF00D, 4'hF, exp_d, exp_e);
        issue(1'b1, 4'd11, 32'hCAFEF00D, 4'hF);
        issue(1'b0, 4'd14, 32'h0, 4'h0);
        checks++;
        if (resp_valid !== 1'b1 || resp_error !== 1'b1 || resp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL oor_load valid=%0b err=%0b rdata=%h exp 1/1/00000000",
                     resp_valid, resp_error, resp_rdata);
        end
        issue(1'b1, 4'd12, 32'hFFFFFFFF, 4'hF);
        checks++;
        if (resp_valid !== 1'b1 || resp_error !== 1'b1 || resp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL oor_store valid=%0b err=%0b rdata=%h exp 1/1/00000000",
                     resp_valid, resp_error, resp_rdata);
        end
        model_access(1'b0, 4'd11, 32'h0, 4'h0, exp_d, exp_e);
        issue(1'b0, 4'd11, 32'h0, 4'h0);
        checks++;
        if (resp_rdata !== exp_d || resp_error !== 1'b0) begin
            failures++;
            $display("FAIL oor_neighbor rdata=%h err=%0b exp %h/0", resp_rdata, resp_error, exp_d);
        end
    endtask

    task automatic test_random();
        logic [31:0]   exp_d, d;
        logic          exp_e, wr;
        logic [AW-1:0] a;
        logic [3:0]    s;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                req_valid = 1'b0;
                tick();
                checks++;
                if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_error !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_idle i=%0d valid=%0b rdata=%h err=%0b exp 0/0/0",
                             i, resp_valid, resp_rdata, resp_error);
                end
            end else begin
                wr = 1'($urandom_range(0, 1));
                a  = AW'($urandom_range(0, 15));
                d  = $urandom;
                s  = 4'($urandom_range(0, 15));
                model_access(wr, a, d, s, exp_d, exp_e);
                issue(wr, a, d, s);
                checks++;
                if (resp_valid !== 1'b1 || resp_rdata !== exp_d || resp_error !== exp_e) begin
                    failures++;
                    $display("FAIL rand_txn i=%0d wr=%0b addr=%0d valid=%0b rdata=%h err=%0b exp 1/%h/%0b",
                             i, wr, a, resp_valid, resp_rdata, resp_error, exp_d, exp_e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        logic saw;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (6) tick();
        checks++;
        if (req_ready !== 1'b0 || clear_busy !== 1'b1) begin
            failures++;
            $display("FAIL midclear_busy ready=%0b busy=%0b exp 0/1", req_ready, clear_busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_ready(n, saw);
        checks++;
        if (n !== DEPTH) begin
            failures++;
            $display("FAIL midclear_restart got=%0d exp=%0d", n, DEPTH);
        end
        model_clear();
        for (int a = 0; a < DEPTH; a++) begin
            issue(1'b0, AW'(a), 32'h0, 4'h0);
            checks++;
            if (resp_rdata !== 32'h0) begin
                failures++;
                $display("FAIL midclear_zero addr=%0d got=%h exp=00000000", a, resp_rdata);
            end
        end
    endtask

    task automatic test_reset_after_load();
        int n;
        logic saw;
        logic [31:0] exp_d;
        logic        exp_e;
        for (int a = 0; a < DEPTH; a++) begin
            model_access(1'b1, AW'(a), $urandom | 32'h1, 4'hF, exp_d, exp_e);
            issue(1'b1, AW'(a), model_mem[a], 4'hF);
        end
        issue(1'b0, 4'd7, 32'h0, 4'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rstload_discard valid=%0b rdata=%h exp 0/00000000",
                     resp_valid, resp_rdata);
        end
        wait_ready(n, saw);
        checks++;
        if (saw !== 1'b0 || n !== DEPTH) begin
            failures++;
            $display("FAIL rstload_clear saw_resp=%0b cycles=%0d exp 0/%0d", saw, n, DEPTH);
        end
        model_clear();
        for (int a = 0; a < DEPTH; a++) begin
            issue(1'b0, AW'(a), 32'h0, 4'h0);
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h0) begin
                failures++;
                $display("FAIL rstload_zero addr=%0d valid=%0b got=%h exp 1/00000000",
                         a, resp_valid, resp_rdata);
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_address = '0;
        req_wdata   = '0;
        req_strobe  = '0;
        test_reset();
        test_byte_strobe();
        test_back_to_back();
        test_out_of_range();
        test_random();
        test_reset_mid_clear();
        test_reset_after_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
